// File: rtl/axi_burst_arbiter.sv
// rtl/axi_burst_arbiter.sv - round-robin arbiter sharing one AXI4 master port
// One transaction at a time: grant, address phase, data phase, response.
module axi_burst_arbiter #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*8-1:0]        req_len,
   input  logic [NREQ*DATA_W-1:0]   wr_data,
   input  logic [NREQ-1:0]          wr_valid,
   output logic [NREQ-1:0]          wr_ready,
   output logic [DATA_W-1:0]        rd_data,
   output logic [NREQ-1:0]          rd_valid,
   output logic                     rd_last,
   output logic [NREQ-1:0]          done,
   output logic [1:0]               resp,
   output logic [ADDR_W-1:0]        awaddr,
   output logic [7:0]               awlen,
   output logic [2:0]               awsize,
   output logic [1:0]               awburst,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [DATA_W-1:0]        wdata,
   output logic [DATA_W/8-1:0]      wstrb,
   output logic                     wlast,
   output logic                     wvalid,
   input  logic                     wready,
   input  logic [1:0]               bresp,
   input  logic                     bvalid,
   output logic                     bready,
   output logic [ADDR_W-1:0]        araddr,
   output logic [7:0]               arlen,
   output logic [2:0]               arsize,
   output logic [1:0]               arburst,
   output logic                     arvalid,
   input  logic                     arready,
   input  logic [DATA_W-1:0]        rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rvalid,
   output logic                     rready
);

   localparam int         IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [2:0] BEAT_SIZE  = 3'($clog2(DATA_W/8));
   localparam logic [1:0] BURST_INCR = 2'b01;

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     ptr, gnt, gnt_q;
   logic              gnt_found;
   logic [NREQ-1:0]   gnt_oh;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        len_q, cnt;
   logic [1:0]        racc;
   logic              w_hs, r_hs;

   // First requester at or after ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt       = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found && req_valid[(int'(ptr) + k) % NREQ]) begin
            gnt_found = 1'b1;
            gnt       = IW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   assign gnt_oh = NREQ'(1) << gnt_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state  <= S_IDLE;
         ptr    <= '0;
         gnt_q  <= '0;
         addr_q <= '0;
         len_q  <= '0;
         cnt    <= '0;
         racc   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && gnt_found) begin
            ptr    <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
            gnt_q  <= gnt;
            addr_q <= req_addr[gnt*ADDR_W +: ADDR_W];
            len_q  <= req_len[gnt*8 +: 8];
            cnt    <= '0;
            racc   <= '0;
         end
         if (w_hs)
            cnt <= cnt + 8'd1;
         // Keep only the first non-OKAY read response of the burst.
         if (r_hs && racc == 2'b00)
            racc <= rresp;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      wr_ready  = '0;
      rd_data   = '0;
      rd_valid  = '0;
      rd_last   = 1'b0;
      done      = '0;
      resp      = '0;
      awaddr    = '0;
      awlen     = '0;
      awsize    = '0;
      awburst   = '0;
      awvalid   = 1'b0;
      wdata     = '0;
      wstrb     = '0;
      wlast     = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      araddr    = '0;
      arlen     = '0;
      arsize    = '0;
      arburst   = '0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      w_hs      = 1'b0;
      r_hs      = 1'b0;
      case (state)
         S_IDLE: begin
            if (gnt_found) begin
               req_ready = NREQ'(1) << gnt;
               state_nxt = req_write[gnt] ? S_AW : S_AR;
            end
         end
         S_AW: begin
            awvalid = 1'b1;
            awaddr  = addr_q;
            awlen   = len_q;
            awsize  = BEAT_SIZE;
            awburst = BURST_INCR;
            if (awready)
               state_nxt = S_W;
         end
         S_W: begin
            wvalid   = wr_valid[gnt_q];
            wdata    = wr_data[gnt_q*DATA_W +: DATA_W];
            wstrb    = '1;
            wlast    = (cnt == len_q);
            wr_ready = gnt_oh & {NREQ{wready}};
            w_hs     = wvalid && wready;
            if (w_hs && wlast)
               state_nxt = S_B;
         end
         S_B: begin
            bready = 1'b1;
            if (bvalid) begin
               done      = gnt_oh;
               resp      = bresp;
               state_nxt = S_IDLE;
            end
         end
         S_AR: begin
            arvalid = 1'b1;
            araddr  = addr_q;
            arlen   = len_q;
            arsize  = BEAT_SIZE;
            arburst = BURST_INCR;
            if (arready)
               state_nxt = S_R;
         end
         S_R: begin
            rready   = 1'b1;
            rd_valid = gnt_oh & {NREQ{rvalid}};
            rd_data  = rdata;
            rd_last  = rlast;
            r_hs     = rvalid;
            if (rvalid && rlast) begin
               done      = gnt_oh;
               resp      = (racc != 2'b00) ? racc : rresp;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// tb/tb_axi_burst_arbiter.sv - directed bench for axi_burst_arbiter
module tb_axi_burst_arbiter;

   logic        aclk;
   logic        aresetn;
   logic [1:0]  req_valid, req_ready, req_write;
   logic [63:0] req_addr;
   logic [15:0] req_len;
   logic [63:0] wr_data;
   logic [1:0]  wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic [1:0]  rd_valid;
   logic        rd_last;
   logic [1:0]  done, resp;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;

   int checks = 0;
   int errors = 0;

   axi_burst_arbiter #(.NREQ(2), .ADDR_W(32), .DATA_W(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
      .done(done), .resp(resp),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr_txn(input int r, input logic [31:0] addr, input logic [7:0] len,
                         input logic [31:0] dbase, input bit stall, input bit keep,
                         input int abort_beat);
      int  beats;
      bit  pend;
      bit  ok;
      bit  aborted;
      req_valid[r] = 1'b1;
      req_write[r] = 1'b1;
      req_addr[r*32 +: 32] = addr;
      req_len[r*8 +: 8] = len;
      #1 chk("grant", req_ready, 64'(1) << r);
      @(posedge aclk); #1;
      if (!keep) req_valid[r] = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         chk("awvalid", awvalid, 1);
         chk("awaddr", awaddr, addr);
         chk("awlen", awlen, len);
         chk("awsize_burst", {awsize, awburst}, {3'd2, 2'd1});
         @(posedge aclk); #1;
         if (awready) begin ok = 1'b1; break; end
      end
      awready = 1'b0;
      if (!ok) chk("aw_timeout", 0, 1);
      beats = 0; pend = 1'b0; ok = 1'b0; aborted = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!pend) begin
            wr_valid[r] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data[r*32 +: 32] = dbase + beats;
         end
         pend   = wr_valid[r];
         wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         chk("wvalid", wvalid, wr_valid[r]);
         chk("wr_ready", wr_ready, 64'(wready) << r);
         if (wr_valid[r]) begin
            chk("wdata", wdata, dbase + beats);
            chk("wlast", wlast, beats == int'(len));
            chk("wstrb", wstrb, 4'hF);
         end
         if (beats == abort_beat) begin
            aresetn = 1'b0;
            #1 chk("rst_outs", {awvalid, wvalid, arvalid, bready, rready, req_ready,
                                wr_ready, done, rd_valid, resp, wdata}, 0);
            aborted = 1'b1;
            break;
         end
         if (wr_valid[r] && wready) begin beats++; pend = 1'b0; end
         @(posedge aclk); #1;
         if (beats > int'(len)) begin ok = 1'b1; break; end
      end
      wr_valid[r] = 1'b0;
      wready = 1'b0;
      if (!aborted) begin
         if (!ok) chk("w_timeout", 0, 1);
         #1 chk("b_wait_done", done, 0);
         chk("bready", bready, 1);
         bvalid = 1'b1; bresp = 2'd0;
         #1 chk("wr_done", done, 64'(1) << r);
         chk("wr_resp", resp, 0);
         @(posedge aclk); #1;
         bvalid = 1'b0;
         #1 chk("wr_done_clr", done, 0);
      end
   endtask

   task automatic rd_txn(input int r, input logic [31:0] addr, input logic [7:0] len,
                         input logic [31:0] dbase, input int bad, input logic [1:0] exp_resp);
      req_valid[r] = 1'b1;
      req_write[r] = 1'b0;
      req_addr[r*32 +: 32] = addr;
      req_len[r*8 +: 8] = len;
      #1 chk("rd_grant", req_ready, 64'(1) << r);
      @(posedge aclk); #1;
      req_valid[r] = 1'b0;
      arready = 1'b1;
      #1;
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, addr);
      chk("arlen", arlen, len);
      chk("arsize_burst", {arsize, arburst}, {3'd2, 2'd1});
      @(posedge aclk); #1;
      arready = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         rvalid = 1'b1;
         rdata  = dbase + b;
         rresp  = (b == bad) ? 2'd2 : 2'd0;
         rlast  = (b == int'(len));
         #1;
         chk("rd_valid", rd_valid, 64'(1) << r);
         chk("rd_data", rd_data, dbase + b);
         chk("rd_last", rd_last, b == int'(len));
         chk("rd_done", done, (b == int'(len)) ? (64'(1) << r) : 64'(0));
         if (b == int'(len)) chk("rd_resp", resp, exp_resp);
         @(posedge aclk); #1;
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
      #1 chk("rd_done_clr", done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
      wr_data = '0; wr_valid = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
      arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, req_ready, wr_ready,
                         done, rd_valid}, 0);
      chk("rst_resp", resp, 0);
      chk("rst_aw", {awaddr, awlen, awsize, awburst}, 0);
      chk("rst_ar", {araddr, arlen, arsize, arburst}, 0);
      chk("rst_data", {wdata, rd_data}, 0);
      aresetn = 1'b1;
      @(posedge aclk); #1;

      wr_txn(0, 32'h100, 8'd3, 32'hA0, 1'b0, 1'b0, -1);
      rd_txn(1, 32'h100, 8'd3, 32'hA0, -1, 2'd0);

      req_valid = 2'b11;
      req_write = 2'b11;
      for (int t = 0; t < 8; t++)
         wr_txn(t % 2, 32'h200 + t * 4, 8'd0, 32'hB0 + t, 1'b0, 1'b1, -1);
      req_valid = '0;

      wr_txn(0, 32'h300, 8'd15, 32'hC0, 1'b1, 1'b0, -1);
      rd_txn(1, 32'h400, 8'd3, 32'hD0, 1, 2'd2);

      wr_txn(0, 32'h500, 8'd7, 32'hE0, 1'b0, 1'b0, 1);
      @(posedge aclk); #1;
      chk("rst_hold", {awvalid, wvalid, arvalid, bready, rready, req_ready, done}, 0);
      aresetn = 1'b1;
      req_valid[1] = 1'b1;
      req_write[1] = 1'b1;
      wr_txn(0, 32'h600, 8'd1, 32'hF0, 1'b0, 1'b0, -1);
      req_valid = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
